modexp_ctrl: RTL

//  Sequencer for Montgomery modular exponentiation.
//  - Starts when the deserializer has loaded xbar/mbar into operand RAM and presented e, e_idx and mp_count.
//  - Scans e MSB-first from bit e_idx down to 0, using left-to-right square-and-multiply.
//  - Issues one Montgomery-product (MP) command per step to the shared MP engine and waits for its completion.

---
 rtl/rsa_pkg.sv | 32 +++
 rtl/exp_bit_scanner.sv | 48 ++++
 rtl/modexp_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Purpose: shared constants for the modexp sequencer and the operand deserializer.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: datapath widths, operand RAM word addresses, modexp_ctrl state encoding.
package rsa_pkg;

    localparam int N     = 32;
    localparam int NLOG2 = 5;
    localparam int ABITS = 8;

    // Operand RAM word map
    localparam logic [ABITS-1:0] XBAR_ADDR = 8'd0;  // running result, Montgomery domain
    localparam logic [ABITS-1:0] MBAR_ADDR = 8'd2;  // base, Montgomery domain
    localparam logic [ABITS-1:0] ONE_ADDR  = 8'd4;  // constant 1 for the final domain exit

    // Sequencer state encoding
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_SQ    = 4'd1;
    localparam logic [3:0] S_SQ_W  = 4'd2;
    localparam logic [3:0] S_MUL   = 4'd3;
    localparam logic [3:0] S_MUL_W = 4'd4;
    localparam logic [3:0] S_NEXT  = 4'd5;
    localparam logic [3:0] S_FIN   = 4'd6;
    localparam logic [3:0] S_FIN_W = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;

    // True in the single-cycle states that issue an MP command
    function automatic logic is_cmd_state(input logic [3:0] s);
        return (s == S_SQ) || (s == S_MUL) || (s == S_FIN);
    endfunction

endpackage

// File: rtl/exp_bit_scanner.sv
// Purpose: holds the latched exponent and walks its bit index down from e_idx to 0.
// Latency: load/dec take effect on the next clk edge; cur_bit/last are combinational from state.
// Backpressure: none; dec at idx==0 is a no-op (no wrap).
// Ports: clk, rst (async active-low), load + e_in/idx_in, dec, cur_bit = e[idx], last = (idx==0).
module exp_bit_scanner
    import rsa_pkg::*;
#(
    parameter int W    = N,
    parameter int IW   = NLOG2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  e_in,
    input  logic [IW-1:0] idx_in,
    input  logic          dec,
    output logic          cur_bit,
    output logic          last
);

    logic [W-1:0]  e_q,   e_d;
    logic [IW-1:0] idx_q, idx_d;

    always_comb begin
        e_d   = e_q;
        idx_d = idx_q;
        if (load) begin
            e_d   = e_in;
            idx_d = idx_in;
        end else if (dec && (idx_q != '0)) begin
            idx_d = idx_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q   <= '0;
            idx_q <= '0;
        end else begin
            e_q   <= e_d;
            idx_q <= idx_d;
        end
    end

    assign cur_bit = e_q[idx_q];
    assign last    = (idx_q == '0);

endmodule

// File: rtl/modexp_ctrl.sv
// Purpose: left-to-right square-and-multiply sequencer driving a shared Montgomery-product engine.
// Latency: first mp_start one cycle after start; one command in flight, next issued after its mp_done.
// Backpressure: start ignored while busy; mp_done only sampled in the wait states.
// Ports: clk, rst (async active-low); start/e/e_idx/mp_count_in from the deserializer;
//        mp_start/mp_a_addr/mp_b_addr/mp_dst_addr/mp_count to the MP engine, mp_done back; busy, done.
// Config: MODEXP_FROM_MONT_EN adds a final MP(xbar,1) to leave the Montgomery domain before done.
module modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int N_W   = N,
    parameter int NLOG2_W = NLOG2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_W-1:0]     e,
    input  logic [NLOG2_W-1:0] e_idx,
    input  logic [NLOG2_W-1:0] mp_count_in,
    input  logic               mp_done,
    output logic               mp_start,
    output logic [ABITS-1:0]   mp_a_addr,
    output logic [ABITS-1:0]   mp_b_addr,
    output logic [ABITS-1:0]   mp_dst_addr,
    output logic [NLOG2_W-1:0] mp_count,
    output logic               busy,
    output logic               done
);

    logic [3:0]         state_q, state_d;
    logic               busy_q,  busy_d;
    logic [NLOG2_W-1:0] cnt_q,   cnt_d;
    logic [ABITS-1:0]   a_q,     a_d;
    logic [ABITS-1:0]   b_q,     b_d;
    logic               load, dec, cur_bit, last;

    exp_bit_scanner #(.W(N_W), .IW(NLOG2_W)) u_scan (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .e_in    (e),
        .idx_in  (e_idx),
        .dec     (dec),
        .cur_bit (cur_bit),
        .last    (last)
    );

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        load    = 1'b0;
        dec     = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                load    = 1'b1;
                busy_d  = 1'b1;
                cnt_d   = mp_count_in;
                state_d = S_SQ;
            end
            S_SQ:    state_d = S_SQ_W;
            S_SQ_W:  if (mp_done) state_d = cur_bit ? S_MUL : S_NEXT;
            S_MUL:   state_d = S_MUL_W;
            S_MUL_W: if (mp_done) state_d = S_NEXT;
            S_NEXT: begin
                if (last) begin
`ifdef MODEXP_FROM_MONT_EN
                    state_d = S_FIN;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    dec     = 1'b1;
                    state_d = S_SQ;
                end
            end
`ifdef MODEXP_FROM_MONT_EN
            S_FIN:   state_d = S_FIN_W;
            S_FIN_W: if (mp_done) state_d = S_DONE;
`endif
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Operand addresses are loaded on entry to a command state and then
        // held untouched through its wait state.
        case (state_d)
            S_SQ:  begin a_d = XBAR_ADDR; b_d = XBAR_ADDR; end
            S_MUL: begin a_d = MBAR_ADDR; b_d = XBAR_ADDR; end
`ifdef MODEXP_FROM_MONT_EN
            S_FIN: begin a_d = XBAR_ADDR; b_d = ONE_ADDR;  end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign mp_start    = is_cmd_state(state_q);
    assign mp_a_addr   = a_q;
    assign mp_b_addr   = b_q;
    assign mp_dst_addr = XBAR_ADDR;
    assign mp_count    = cnt_q;
    assign busy        = busy_q;
    assign done        = (state_q == S_DONE);

endmodule
